// File: rtl/input_debouncer.sv
// Pushbutton/switch debouncer with memory-mapped KEYDATA, KEYEDGE and SWDATA registers.
// Define INPUT_DEBOUNCER_SW_DEBOUNCE_EN to debounce SW too; otherwise SW is only synchronized.

module input_debouncer_bit #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_in,
  output logic stable_q,
  output logic stable_d
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync_in == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = sync_in;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end
endmodule

module input_debouncer #(
  parameter int DBITS           = 32,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  input  logic             rdEn,
  input  logic             wrtEn,
  input  logic [1:0]       regSel,
  input  logic [DBITS-1:0] wrtData,
  output logic [DBITS-1:0] dataOut
);
  logic [3:0] key_s1_q, key_s2_q;
  logic [9:0] sw_s1_q, sw_s2_q;
  logic [3:0] key_state, key_nxt, key_rise;
  logic [9:0] sw_state;
  logic [3:0] edge_q, edge_d;
  logic       overrun_q, overrun_d;
  logic [3:0] clr_mask, ov_set;
  logic       clr_ov;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1_q <= 4'hF;
      key_s2_q <= 4'hF;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      key_s1_q <= KEY;
      key_s2_q <= key_s1_q;
      sw_s1_q  <= SW;
      sw_s2_q  <= sw_s1_q;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_key
    input_debouncer_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .reset(reset), .sync_in(~key_s2_q[i]),
      .stable_q(key_state[i]), .stable_d(key_nxt[i])
    );
  end

`ifdef INPUT_DEBOUNCER_SW_DEBOUNCE_EN
  logic [9:0] sw_nxt;
  for (genvar i = 0; i < 10; i++) begin : g_sw
    input_debouncer_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .reset(reset), .sync_in(sw_s2_q[i]),
      .stable_q(sw_state[i]), .stable_d(sw_nxt[i])
    );
  end
  logic unused_sw;
  assign unused_sw = ^sw_nxt;
`else
  assign sw_state = sw_s2_q;
`endif

  assign key_rise = key_nxt & ~key_state;

  always_comb begin
    clr_mask = 4'h0;
    clr_ov   = 1'b0;
    if (regSel == 2'd1) begin
      if (rdEn) begin
        clr_mask = 4'hF;
        clr_ov   = 1'b1;
      end
      if (wrtEn) begin
        clr_mask = clr_mask | wrtData[3:0];
        clr_ov   = clr_ov | wrtData[8];
      end
    end
  end

  // A press coinciding with a clear of the same bit is a fresh event, not an overrun.
  always_comb begin
    ov_set    = key_rise & edge_q & ~clr_mask;
    edge_d    = key_rise | (edge_q & ~clr_mask);
    overrun_d = (|ov_set) | (overrun_q & ~clr_ov);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      edge_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      edge_q    <= edge_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    dataOut = '0;
    case (regSel)
      2'd0: dataOut[3:0] = key_state;
      2'd1: begin
        dataOut[3:0] = edge_q;
        dataOut[8]   = overrun_q;
      end
      2'd2: dataOut[9:0] = sw_state;
      default: dataOut = '0;
    endcase
  end

  logic unused_wr;
  assign unused_wr = ^{wrtData[DBITS-1:9], wrtData[7:4]};
endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with DEBOUNCE_CYCLES=4 (stable after 6 edges).
module tb_input_debouncer;
  localparam int DBITS = 32;
`ifdef INPUT_DEBOUNCER_SW_DEBOUNCE_EN
  localparam int SW_LAT = 6;
`else
  localparam int SW_LAT = 2;
`endif

  logic             clk = 0;
  logic             reset = 0;
  logic [3:0]       KEY = 4'hF;
  logic [9:0]       SW = '0;
  logic             rdEn = 0, wrtEn = 0;
  logic [1:0]       regSel = 0;
  logic [DBITS-1:0] wrtData = '0;
  logic [DBITS-1:0] dataOut;
  int pass_cnt = 0, total = 0;
  logic [DBITS-1:0] v;

  input_debouncer #(.DBITS(DBITS), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .KEY(KEY), .SW(SW), .rdEn(rdEn), .wrtEn(wrtEn),
    .regSel(regSel), .wrtData(wrtData), .dataOut(dataOut)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [1:0] sel, output logic [DBITS-1:0] val);
    regSel = sel;
    #1;
    val = dataOut;
  endtask

  task automatic test_reset;
    reset = 1;
    tick(3);
    for (int s = 0; s < 4; s++) begin
      rd(s[1:0], v); total++;
      if (v !== 32'h0) $display("FAIL reset_sel%0d got %h exp 0", s, v); else pass_cnt++;
    end
    reset = 0;
    tick(1);
    for (int s = 0; s < 4; s++) begin
      rd(s[1:0], v); total++;
      if (v !== 32'h0) $display("FAIL post_reset_sel%0d got %h exp 0", s, v); else pass_cnt++;
    end
  endtask

  task automatic test_press;
    KEY[0] = 0;
    tick(5);
    rd(0, v); total++;
    if (v !== 32'h0) $display("FAIL press_early got %h exp 0", v); else pass_cnt++;
    tick(1);
    rd(0, v); total++;
    if (v !== 32'h1) $display("FAIL press_keydata got %h exp 1", v); else pass_cnt++;
    rd(1, v); total++;
    if (v !== 32'h1) $display("FAIL press_keyedge got %h exp 1", v); else pass_cnt++;
    rdEn = 1; regSel = 0;
    tick(1);
    rdEn = 0;
    rd(1, v); total++;
    if (v !== 32'h1) $display("FAIL rd_sel0_noclear got %h exp 1", v); else pass_cnt++;
    rdEn = 1;
    rd(1, v); total++;
    if (v !== 32'h1) $display("FAIL rd_preclear got %h exp 1", v); else pass_cnt++;
    tick(1);
    rdEn = 0;
    rd(1, v); total++;
    if (v !== 32'h0) $display("FAIL rd_cleared got %h exp 0", v); else pass_cnt++;
    KEY[0] = 1;
    tick(6);
    rd(0, v); total++;
    if (v !== 32'h0) $display("FAIL release_keydata got %h exp 0", v); else pass_cnt++;
    rd(1, v); total++;
    if (v !== 32'h0) $display("FAIL release_keyedge got %h exp 0", v); else pass_cnt++;
  endtask

  task automatic test_glitch;
    int bad = 0;
    KEY[1] = 0;
    tick(3);
    KEY[1] = 1;
    for (int i = 0; i < 10; i++) begin
      rd(0, v);
      if (v !== 32'h0) bad++;
      tick(1);
    end
    total++;
    if (bad != 0) $display("FAIL glitch_keydata nonzero in %0d cycles exp 0", bad); else pass_cnt++;
    rd(1, v); total++;
    if (v !== 32'h0) $display("FAIL glitch_keyedge got %h exp 0", v); else pass_cnt++;
  endtask

  task automatic test_overrun;
    KEY[2] = 0; tick(6);
    rd(1, v); total++;
    if (v !== 32'h4) $display("FAIL ovr_first got %h exp 004", v); else pass_cnt++;
    KEY[2] = 1; tick(6);
    KEY[2] = 0; tick(6);
    rd(1, v); total++;
    if (v !== 32'h104) $display("FAIL ovr_second got %h exp 104", v); else pass_cnt++;
    rdEn = 1;
    tick(1);
    rdEn = 0;
    rd(1, v); total++;
    if (v !== 32'h0) $display("FAIL ovr_clear got %h exp 000", v); else pass_cnt++;
    KEY[2] = 1; tick(6);
  endtask

  task automatic test_clear_race;
    KEY[3] = 0; tick(6);
    KEY[3] = 1; tick(6);
    rd(1, v); total++;
    if (v !== 32'h8) $display("FAIL race_pre got %h exp 008", v); else pass_cnt++;
    KEY[3] = 0; tick(5);
    rdEn = 1; regSel = 1;
    tick(1);
    rdEn = 0;
    rd(1, v); total++;
    if (v !== 32'h8) $display("FAIL race_edge got %h exp 008", v); else pass_cnt++;
    wrtData = 32'hFFFF_FFFF; wrtEn = 1; regSel = 0;
    tick(1);
    rd(1, v); total++;
    if (v !== 32'h8) $display("FAIL wr_sel0_ignored got %h exp 008", v); else pass_cnt++;
    wrtData = 32'h108; regSel = 1;
    tick(1);
    wrtEn = 0;
    rd(1, v); total++;
    if (v !== 32'h0) $display("FAIL wr_clear got %h exp 000", v); else pass_cnt++;
    KEY[3] = 1; tick(6);
  endtask

  task automatic test_sw;
    SW = 10'h2A5;
    tick(SW_LAT - 1);
    rd(2, v); total++;
    if (v !== 32'h0) $display("FAIL sw_early got %h exp 0", v); else pass_cnt++;
    tick(1);
    rd(2, v); total++;
    if (v !== 32'h2A5) $display("FAIL sw_data got %h exp 2a5", v); else pass_cnt++;
    rd(3, v); total++;
    if (v !== 32'h0) $display("FAIL reserved got %h exp 0", v); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int bad = 0;
    KEY[0] = 0; tick(2);
    reset = 1; tick(2);
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      rd(0, v); if (v !== 32'h0) bad++;
      rd(1, v); if (v !== 32'h0) bad++;
      tick(1);
    end
    total++;
    if (bad != 0) $display("FAIL rstmid_early nonzero %0d times exp 0", bad); else pass_cnt++;
    rd(0, v); total++;
    if (v !== 32'h0) $display("FAIL rstmid_5 got %h exp 0", v); else pass_cnt++;
    tick(1);
    rd(0, v); total++;
    if (v !== 32'h1) $display("FAIL rstmid_keydata got %h exp 1", v); else pass_cnt++;
    rd(1, v); total++;
    if (v !== 32'h1) $display("FAIL rstmid_keyedge got %h exp 1", v); else pass_cnt++;
  endtask

  initial begin
    #2;
    test_reset;
    test_press;
    test_glitch;
    test_overrun;
    test_clear_race;
    test_sw;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
